// File: rtl/mem_responder.sv
// Single-port memory-mapped responder: 256x16 RAM, switch input and LED register.
// Define WRITE_PROTECT_EN to reject writes to the program region 0x000-0x03F.
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  input  logic [7:0]  sw,
  output logic [15:0] read_data,
  output logic        mem_ready,
  output logic        busy,
  output logic        err,
  output logic [7:0]  led
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [1:0] CmdRead  = 2'b01;
  localparam logic [1:0] CmdWrite = 2'b10;
  localparam logic [8:0] AddrSw   = 9'h100;
  localparam logic [8:0] AddrLed  = 9'h101;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  cmd_q;
  logic [8:0]  addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  led_q, led_d;
  logic        ram_we;
  logic        accept;

  logic [15:0] ram [256];

  assign accept = (state_q == StIdle) && (mem_cmd != 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    led_d   = led_q;
    ram_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StAccess;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      StAccess: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StResp;
          case (cmd_q)
            CmdRead: begin
              if (!addr_q[8]) begin
                rdata_d = ram[addr_q[7:0]];
              end else if (addr_q == AddrSw) begin
                rdata_d = {8'h00, sw};
              end else if (addr_q == AddrLed) begin
                rdata_d = {8'h00, led_q};
              end else begin
                rdata_d = 16'h0000;
                err_d   = 1'b1;
              end
            end
            CmdWrite: begin
              // Writes never touch read_data.
              if (!addr_q[8]) begin
`ifdef WRITE_PROTECT_EN
                if (addr_q[7:6] == 2'b00) begin
                  err_d = 1'b1;
                end else begin
                  ram_we = 1'b1;
                end
`else
                ram_we = 1'b1;
`endif
              end else if (addr_q == AddrLed) begin
                led_d = wdata_q[7:0];
              end else begin
                err_d = 1'b1;
              end
            end
            default: begin
              rdata_d = 16'h0000;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
      led_q   <= 8'h00;
      cmd_q   <= 2'b00;
      addr_q  <= 9'h000;
      wdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      led_q   <= led_d;
      if (accept) begin
        cmd_q   <= mem_cmd;
        addr_q  <= mem_addr;
        wdata_q <= write_data;
      end
    end
  end

  // RAM is not reset; reset on the commit edge still blocks the write.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      ram[addr_q[7:0]] <= wdata_q;
    end
  end

  assign read_data = rdata_q;
  assign mem_ready = (state_q == StResp);
  assign busy      = (state_q != StIdle);
  assign err       = err_q;
  assign led       = led_q;

endmodule
